// File: rtl/ntt_seq_ctrl.sv
// rtl/ntt_seq_ctrl.sv - load/kick/read sequencer for the 1536-point NTT core (optional cycle counter: NTT_SEQ_CYCCNT_EN)
module ntt_seq_ctrl #(
    parameter int N         = 1536,
    parameter int AW        = 11,
    parameter int DW_IN     = 13,
    parameter int DW_OUT    = 14,
    parameter int GAP       = 8,
    parameter int RD_LAT    = 4,
    parameter int RD_STRIDE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              src_sel,
    output logic [AW-1:0]     src_addr,
    input  logic [DW_IN-1:0]  src_data,
    output logic              ntt_start,
    output logic              ntt_input_fg,
    output logic [AW-1:0]     ntt_addr,
    output logic [DW_IN-1:0]  ntt_din,
    input  logic              ntt_valid,
    input  logic [DW_OUT-1:0] ntt_dout,
    output logic              h_valid,
    output logic [AW-1:0]     h_addr,
    output logic [DW_OUT-1:0] h_data,
    output logic [15:0]       cyc_cnt
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD_F = 4'd1;
    localparam logic [3:0] S_GAP_F  = 4'd2;
    localparam logic [3:0] S_LOAD_G = 4'd3;
    localparam logic [3:0] S_GAP_G  = 4'd4;
    localparam logic [3:0] S_KICK   = 4'd5;
    localparam logic [3:0] S_WAIT   = 4'd6;
    localparam logic [3:0] S_READ   = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam int CMAX = (GAP > RD_STRIDE) ? GAP : RD_STRIDE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW-1:0] K_LAST   = AW'(N - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0] STR_LAST = CW'(RD_STRIDE - 1);

    logic [3:0]       r_state;
    logic [AW-1:0]    r_k;
    logic [CW-1:0]    r_cnt;
    logic             r_rd_end;

    logic             r_v1, r_v2, r_s1, r_fg;
    logic [AW-1:0]    r_a1, r_a2;
    logic [DW_IN-1:0] r_din;

    logic [RD_LAT-1:0] r_tag;
    logic [AW-1:0]     r_pa [RD_LAT];

    logic w_load, w_issue, w_h_last;

    assign w_load   = (r_state == S_LOAD_F) || (r_state == S_LOAD_G);
    assign w_issue  = (r_state == S_READ) && (r_cnt == '0) && !r_rd_end;
    assign w_h_last = r_tag[RD_LAT-1] && (r_pa[RD_LAT-1] == K_LAST);

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign src_sel      = (r_state == S_LOAD_G);
    assign src_addr     = w_load ? r_k : '0;
    assign ntt_start    = (r_state == S_KICK);
    assign ntt_input_fg = r_fg;
    assign ntt_addr     = r_v2 ? r_a2 : ((r_state == S_READ) ? r_k : '0);
    assign ntt_din      = r_din;
    assign h_valid      = r_tag[RD_LAT-1];
    assign h_addr       = r_tag[RD_LAT-1] ? r_pa[RD_LAT-1] : '0;
    assign h_data       = r_tag[RD_LAT-1] ? ntt_dout : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_cnt    <= '0;
            r_rd_end <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state <= S_LOAD_F;
                        r_k     <= '0;
                    end
                end
                S_LOAD_F, S_LOAD_G: begin
                    if (r_k == K_LAST) begin
                        r_state <= (r_state == S_LOAD_F) ? S_GAP_F : S_GAP_G;
                        r_k     <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_k <= r_k + AW'(1);
                    end
                end
                S_GAP_F, S_GAP_G: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= (r_state == S_GAP_F) ? S_LOAD_G : S_KICK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_KICK: r_state <= S_WAIT;
                S_WAIT: begin
                    if (ntt_valid) begin
                        r_state  <= S_READ;
                        r_k      <= '0;
                        r_cnt    <= '0;
                        r_rd_end <= 1'b0;
                    end
                end
                S_READ: begin
                    if (r_cnt == STR_LAST) begin
                        r_cnt <= '0;
                        if (r_k != K_LAST) r_k <= r_k + AW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_issue && (r_k == K_LAST)) r_rd_end <= 1'b1;
                    // Leave once the final tagged address has come back out of the delay line.
                    if (w_h_last) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory has one cycle of read latency, so din is captured one cycle after the address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_s1  <= 1'b0;
            r_fg  <= 1'b0;
            r_a1  <= '0;
            r_a2  <= '0;
            r_din <= '0;
        end else begin
            r_v1  <= w_load;
            r_a1  <= src_addr;
            r_s1  <= src_sel;
            r_v2  <= r_v1;
            r_a2  <= r_a1;
            r_din <= r_v1 ? src_data : '0;
            if ((r_state == S_WAIT) && ntt_valid) r_fg <= 1'b0;
            else if (r_v1)                        r_fg <= r_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tag <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pa[i] <= '0;
        end else begin
            r_tag[0] <= w_issue;
            r_pa[0]  <= r_k;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
                r_pa[i]  <= r_pa[i-1];
            end
        end
    end

`ifdef NTT_SEQ_CYCCNT_EN
    logic [15:0] r_cyc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cyc <= '0;
        end else if (r_state == S_KICK) begin
            r_cyc <= '0;
        end else if ((r_state == S_WAIT) && (r_cyc != 16'hFFFF)) begin
            r_cyc <= r_cyc + 16'd1;
        end
    end

    assign cyc_cnt = r_cyc;
`else
    assign cyc_cnt = 16'd0;
`endif

endmodule
